data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the memory pipeline stage and a slower backing main memory.
- Consumes the memory-stage address, write data, funct3 and control bits that currently drive the data memory. Returns load data to the memory/writeback register.
- Raises stallM to the hazard unit while a refill or write-through is in progress.

---
 rtl/data_cache.sv | 197 +++++++++++++++++++
 tb/tb_data_cache.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache that
// sits between the memory pipeline stage and a slower backing memory.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   aluresultM            byte address of the access
//   memreadM, memwriteM   load / store request (store wins if both set)
//   funct3M               access size/sign (B, H, W, BU, HU)
//   writedataM            store data, right-aligned
//   readdataM             load result, sign/zero-extended (0 when not a hit)
//   stallM                freeze F/D/E/M while a refill or write-through runs
//   mem_req/mem_we        backing request valid / write select
//   mem_addr              word-aligned backing address
//   mem_wdata/mem_wstrb   lane-placed write data and byte enables
//   mem_ready             request accepted (read data valid in same cycle)
//   mem_rdata             backing read data
module data_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] aluresultM,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [SETS-1:0]        valid_q;
    logic [TAG_W-1:0]       tag_q  [SETS];
    logic [31:0]            data_q [SETS*WORDS_PER_LINE];

    logic [OFF_W-1:0]       a_off;
    logic [IDX_W-1:0]       a_idx;
    logic [TAG_W-1:0]       a_tag;
    logic                   line_hit;
    logic [31:0]            word_sel;
    logic [31:0]            st_wdata;
    logic [3:0]             st_wstrb;

    logic                   fill_we;   // write mem_rdata into word cnt_q
    logic                   fill_last; // final refill word: validate line
    logic                   inval;     // line about to be overwritten by refill
    logic                   wr_upd;    // merge store bytes into cached word

    assign a_off    = aluresultM[OFF_W+1:2];
    assign a_idx    = aluresultM[OFF_W+IDX_W+1:OFF_W+2];
    assign a_tag    = aluresultM[31:OFF_W+IDX_W+2];
    assign line_hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign word_sel = data_q[{a_idx, a_off}];

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] bo);
        logic [31:0] sh;
        sh = w >> {bo[1], (bo[1] ? 1'b0 : 1'b0), 3'b000} ;
        case (f3)
            3'b000:  begin sh = w >> {bo, 3'b000};      return {{24{sh[7]}},  sh[7:0]};  end
            3'b001:  begin sh = w >> {bo[1], 4'b0000};  return {{16{sh[15]}}, sh[15:0]}; end
            3'b100:  begin sh = w >> {bo, 3'b000};      return {24'b0, sh[7:0]};         end
            3'b101:  begin sh = w >> {bo[1], 4'b0000};  return {16'b0, sh[15:0]};        end
            default: return w;
        endcase
    endfunction

    // Store lane placement: sub-word data is replicated so the strobes pick it.
    always_comb begin
        case (funct3M[1:0])
            2'b00: begin
                st_wdata = {4{writedataM[7:0]}};
                st_wstrb = 4'b0001 << aluresultM[1:0];
            end
            2'b01: begin
                st_wdata = {2{writedataM[15:0]}};
                st_wstrb = 4'b0011 << {aluresultM[1], 1'b0};
            end
            default: begin
                st_wdata = writedataM;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stallM    = 1'b0;
        readdataM = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {aluresultM[31:2], 2'b00};
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        fill_we   = 1'b0;
        fill_last = 1'b0;
        inval     = 1'b0;
        wr_upd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memwriteM) begin
                    stallM  = 1'b1;
                    state_d = S_WRITE;
                end else if (memreadM) begin
                    if (line_hit) begin
                        readdataM = extract(word_sel, funct3M, aluresultM[1:0]);
                    end else begin
                        stallM  = 1'b1;
                        state_d = S_REFILL;
                        cnt_d   = '0;
                        inval   = 1'b1;
                    end
                end
            end
            S_REFILL: begin
                stallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {a_tag, a_idx, cnt_q, 2'b00};
                if (mem_ready) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        fill_last = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                stallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = st_wdata;
                mem_wstrb = st_wstrb;
                if (mem_ready) begin
                    // Release the stall on the accept cycle so the store retires once.
                    stallM  = 1'b0;
                    state_d = S_IDLE;
                    wr_upd  = line_hit;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            stallM    = 1'b0;
            readdataM = 32'h0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            fill_we   = 1'b0;
            fill_last = 1'b0;
            inval     = 1'b0;
            wr_upd    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (inval)     valid_q[a_idx] <= 1'b0;
            if (fill_last) valid_q[a_idx] <= 1'b1;
        end
    end

    // Tag/data arrays are not reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (fill_we)   data_q[{a_idx, cnt_q}] <= mem_rdata;
        if (fill_last) tag_q[a_idx] <= a_tag;
        if (wr_upd) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb[b]) data_q[{a_idx, a_off}][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a simple backing memory.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluresultM, writedataM, readdataM;
    logic        memreadM, memwriteM;
    logic [2:0]  funct3M;
    logic        stallM, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [4096];
    logic        tog;
    logic        tgl = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          hold_err = 0;
    logic [31:0] rd_log [$];
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];
    logic [3:0]  ws_log [$];

    int ncomp = 0;
    int nfail = 0;

    data_cache dut (
        .clk(clk), .rst(rst), .aluresultM(aluresultM), .memreadM(memreadM),
        .memwriteM(memwriteM), .funct3M(funct3M), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_ready = tog ? tgl : 1'b1;
    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        #1 tgl = ~tgl;
    end

    // Inputs only change just after posedge, so negedge values are what the
    // DUT will see at the next active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend && mem_req && mem_addr !== pend_addr) hold_err++;
            pend      = mem_req && !mem_ready;
            pend_addr = mem_addr;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    wa_log.push_back(mem_addr);
                    wd_log.push_back(mem_wdata);
                    ws_log.push_back(mem_wstrb);
                end else begin
                    rd_log.push_back(mem_addr);
                end
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        memreadM   = rd;
        memwriteM  = wr;
        funct3M    = f3;
        aluresultM = a;
        writedataM = wd;
    endtask

    task automatic wait_free(output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallM) done = 1'b1;
            else stalls++;
        end
        #1;
        if (!done) begin
            ncomp++;
            nfail++;
            $error("FAIL stall_timeout: observed stalled expected release");
        end
    endtask

    task automatic hit(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        #1;
        chk({tag, "_stall"}, 32'(stallM), 32'h0);
        chk(tag, readdataM, exp);
    endtask

    task automatic apply_wr(input int k);
        logic [31:0] a, d;
        logic [3:0]  s;
        a = wa_log[k];
        d = wd_log[k];
        s = ws_log[k];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic chk_reads(input string tag, input int base, input logic [31:0] a0);
        chk({tag, "_nreads"}, 32'(rd_log.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (rd_log.size() > base + k) chk({tag, "_raddr"}, rd_log[base+k], a0 + 32'(4*k));
        end
    endtask

    task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int k;
        k = wa_log.size() - 1;
        chk({tag, "_nwrites"}, 32'(wa_log.size()), 32'(k + 1));
        if (k >= 0) begin
            chk({tag, "_waddr"}, wa_log[k], a);
            chk({tag, "_wdata"}, wd_log[k], d);
            chk({tag, "_wstrb"}, 32'(ws_log[k]), 32'(s));
            apply_wr(k);
        end
    endtask

    initial begin
        int s;
        int base;
        int nw;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2]  = 32'h11;
        mem[32'h104 >> 2]  = 32'h22;
        mem[32'h108 >> 2]  = 32'h33;
        mem[32'h10C >> 2]  = 32'h44;
        mem[32'h1100 >> 2] = 32'hCAFE0001;
        mem[32'h1104 >> 2] = 32'hCAFE0002;
        mem[32'h1108 >> 2] = 32'hCAFE0003;
        mem[32'h110C >> 2] = 32'hCAFE0004;
        tog = 1'b0;
        rst = 1'b1;
        memreadM = 1'b0; memwriteM = 1'b0; funct3M = 3'b010;
        aluresultM = 32'h0; writedataM = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stallM), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_rdata", readdataM, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(stallM), 32'h0);
        chk("idle_req", 32'(mem_req), 32'h0);

        // Cold load miss: 1 IDLE + 4 refill cycles of stall
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
        wait_free(s);
        chk("cold_stalls", 32'(s), 32'd5);
        chk("cold_data", readdataM, 32'h33);
        chk_reads("cold", base, 32'h100);
        hit("hit_10c", 3'b010, 32'h10C, 32'h44);

        // Store-hit full word to set up the sub-word pattern
        nw = wa_log.size();
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF7F01);
        wait_free(s);
        chk("sw_stalls", 32'(s), 32'd1);
        chk_write("sw_hit", 32'h100, 32'h80FF7F01, 4'b1111);
        hit("lw_100", 3'b010, 32'h100, 32'h80FF7F01);

        hit("lb_101",  3'b000, 32'h101, 32'h0000007F);
        hit("lb_102",  3'b000, 32'h102, 32'hFFFFFFFF);
        hit("lbu_103", 3'b100, 32'h103, 32'h00000080);
        hit("lh_102",  3'b001, 32'h102, 32'hFFFF80FF);
        hit("lhu_100", 3'b101, 32'h100, 32'h00007F01);

        // Store-byte hit
        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AA);
        wait_free(s);
        chk("sb_stalls", 32'(s), 32'd1);
        chk_write("sb_hit", 32'h100, 32'hAAAAAAAA, 4'b0010);
        hit("lw_after_sb", 3'b010, 32'h100, 32'h80FFAA01);

        // Store miss: no allocate, other lines untouched
        issue(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678);
        wait_free(s);
        chk("swm_stalls", 32'(s), 32'd1);
        chk_write("sw_miss", 32'h400, 32'h12345678, 4'b1111);
        hit("lw_100_kept", 3'b010, 32'h100, 32'h80FFAA01);
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        wait_free(s);
        chk("lw400_stalls", 32'(s), 32'd5);
        chk("lw400_data", readdataM, 32'h12345678);
        chk_reads("lw400", base, 32'h400);

        // Conflict miss with toggling ready
        tog = 1'b1;
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h1100, 32'h0);
        wait_free(s);
        tog = 1'b0;
        chk("bp_stalls_ge8", 32'(s >= 8), 32'h1);
        chk("bp_data", readdataM, 32'hCAFE0001);
        chk_reads("bp", base, 32'h1100);
        chk("bp_addr_hold", 32'(hold_err), 32'h0);
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        wait_free(s);
        chk("evict_stalls", 32'(s), 32'd5);
        chk("evict_data", readdataM, 32'h80FFAA01);
        chk_reads("evict", base, 32'h100);

        // Reset in the middle of a refill
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h1108, 32'h0);
        for (int i = 0; i < 20 && (rd_log.size() - base) < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_nreads", 32'(rd_log.size() - base), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        memreadM = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'h0);
        chk("abort_stall", 32'(stallM), 32'h0);
        base = rd_log.size();
        issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
        wait_free(s);
        chk("rerun_stalls", 32'(s), 32'd5);
        chk("rerun_data", readdataM, 32'h33);
        chk_reads("rerun", base, 32'h100);

        issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
